// File: rtl/clkspec_ncr_mul_interleave.sv
// N-way time-interleaved multiplier: a round-robin slot pointer demuxes operands into lanes and merges lane products back.
// Optional saturating result counter enabled by defining CLKSPEC_NCR_MUL_CNT_EN.
module clkspec_ncr_mul_interleave #(
    parameter  int WIDTH  = 8,
    parameter  int LANES  = 4,
    parameter  int SIGNED = 0,
    localparam int SW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   dout,
    output logic                 dout_valid,
    output logic [SW-1:0]        dout_lane,
    output logic [SW-1:0]        slot
`ifdef CLKSPEC_NCR_MUL_CNT_EN
    ,
    output logic [15:0]          result_cnt
`endif
);

    logic [SW-1:0]        r_slot;
    logic [SW-1:0]        w_slot_next;
    logic [2*WIDTH-1:0]   r_dout;
    logic                 r_dout_valid;
    logic [SW-1:0]        r_dout_lane;
    logic [LANES-1:0]     w_lane_valid;
    logic [2*WIDTH-1:0]   w_prod [LANES];

    assign w_slot_next = (LANES == 1 || r_slot == SW'(LANES - 1)) ? '0 : r_slot + SW'(1);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0]   r_a;
            logic [WIDTH-1:0]   r_b;
            logic               r_v;
            logic [2*WIDTH-1:0] w_ext_a;
            logic [2*WIDTH-1:0] w_ext_b;

            // Extending to the full product width makes a truncated 2W-bit multiply exact for both signednesses.
            assign w_ext_a = (SIGNED != 0) ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
            assign w_ext_b = (SIGNED != 0) ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
            // Multicycle path: operands are stable for LANES cycles before this product is sampled.
            assign w_prod[gi]       = w_ext_a * w_ext_b;
            assign w_lane_valid[gi] = r_v;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_v <= 1'b0;
                end else if (sync_clr) begin
                    r_v <= 1'b0;
                end else if (r_slot == SW'(gi)) begin
                    r_a <= a;
                    r_b <= b;
                    r_v <= in_valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_lane  <= '0;
        end else if (sync_clr) begin
            r_slot       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_slot       <= w_slot_next;
            r_dout_valid <= w_lane_valid[r_slot];
            r_dout_lane  <= r_slot;
            if (w_lane_valid[r_slot]) begin
                r_dout <= w_prod[r_slot];
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_lane  = r_dout_lane;
    assign slot       = r_slot;

`ifdef CLKSPEC_NCR_MUL_CNT_EN
    logic [15:0] r_result_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_cnt <= '0;
        end else if (sync_clr) begin
            r_result_cnt <= '0;
        end else if (r_dout_valid && r_result_cnt != 16'hFFFF) begin
            r_result_cnt <= r_result_cnt + 16'd1;
        end
    end

    assign result_cnt = r_result_cnt;
`endif

endmodule

// File: doc/clkspec_ncr_mul_interleave.md
Name: clkspec_ncr_mul_interleave

Overview:
- Parametrised N-way time-interleaved multiplier, successor to the 2-way clock-spec NCR multiplier.
- A round-robin slot pointer demuxes one operand pair per cycle into one of LANES lane registers.
- Each lane holds its operands for LANES cycles, giving each lane's multiplier a LANES-cycle multicycle window.
- The same pointer merges lane products back into a single registered output stream at one result per cycle, with fixed latency.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- LANES, 4, number of interleaved lanes (1..8); also the fixed latency in cycles.
- SIGNED, 0, 0 = unsigned product, 1 = two's-complement signed product.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- sync_clr  input  1  synchronous flush of pipeline state.
- in_valid  input  1  operand pair a/b is valid this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- dout  output  2*WIDTH  registered product.
- dout_valid  output  1  dout holds a new result this cycle.
- dout_lane  output  clog2(LANES) (min 1)  lane that produced the current dout.
- slot  output  clog2(LANES) (min 1)  current round-robin pointer.

Behaviour:
- Reset (async, reset=1): slot=0; all lane operand registers=0; all lane valid bits=0; dout=0; dout_valid=0; dout_lane=0.
- slot advances every posedge: 0,1,...,LANES-1,0. It advances unconditionally and is independent of in_valid. LANES=1 means slot stays 0.
- At each posedge, with p = slot before the edge, the following happen simultaneously:
  - Output capture: dout_valid <= lane_valid[p] and dout_lane <= p. If lane_valid[p]=1, dout <= lane_a[p]*lane_b[p]; otherwise dout holds its previous value.
  - Dispatch: lane_a[p] <= a, lane_b[p] <= b, lane_valid[p] <= in_valid. When in_valid=0, operands are still loaded but the lane is marked invalid.
- Latency: operands sampled at posedge k appear on dout with dout_valid=1 after posedge k+LANES. Throughput is 1 result per cycle; input order is preserved.
- No backpressure: the consumer must accept dout every cycle it is valid.
- Arithmetic: full 2*WIDTH product, no truncation or overflow.
  - SIGNED=1: both operands sign-extended.
  - SIGNED=0: both zero-extended.
- Multicycle: lane operands are stable for exactly LANES cycles. The lane product is only sampled at the edge ending that window. Timing constraints declare a LANES-cycle multicycle path from lane registers to dout.
- sync_clr=1 at a posedge overrides dispatch and capture:
  - slot <= 0; all lane_valid <= 0; dout_valid <= 0.
  - dout and lane operands hold.
  - Operands presented on that cycle are dropped.
- reset asserted mid-stream: all in-flight results are lost immediately. No dout_valid until new data has traversed LANES cycles after reset release.
- Boundary case: in_valid=1 on the slot wrap edge (p=LANES-1) behaves like any other slot.

Optional Feature:
- Macro: CLKSPEC_NCR_MUL_CNT_EN.
- When defined:
  - Adds output port result_cnt, 16 bits: a saturating count of cycles with dout_valid=1.
  - Reset and sync_clr set it to 0.
  - It sticks at 16'hFFFF once reached.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, LANES=4 unless noted):
- Reset, then a=3,b=5,in_valid=1 for one cycle at slot 0 -> after 4 posedges dout=16'd15, dout_valid=1, dout_lane=0; all other cycles dout_valid=0.
- Stream a=i+1, b=2*i+1 (i=0..7) on consecutive cycles -> dout_valid high for 8 consecutive cycles starting at latency 4; dout = 1,6,15,28,45,66,91,120; dout_lane = 0,1,2,3,0,1,2,3.
- Alternate in_valid 1/0 with a=255,b=255 -> dout=16'hFE01 valid on every other cycle; dout holds 16'hFE01 on the invalid cycles.
- SIGNED=1: a=8'hFF (-1), b=8'h80 (-128) -> dout=16'h0080 (+128). SIGNED=0, same operands -> dout=16'h7F80.
- Stream 4 valid pairs, assert sync_clr two cycles later -> the two pairs not yet output never appear; slot=0 on the next cycle; a new pair emerges exactly 4 cycles after it is entered.
- Assert reset asynchronously between edges mid-stream -> dout=0, dout_valid=0, slot=0 immediately. With CLKSPEC_NCR_MUL_CNT_EN defined, result_cnt=0; after 70000 valid results result_cnt=16'hFFFF.
